// File: rtl/mux_pkg.sv
// Shared constants, grant record and round-robin search for the mux/demux/merge family.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Upper bound on channel count that next_rr is sized for.
  localparam int unsigned MaxCh   = 16;
  localparam int unsigned MaxSelW = 4;

  typedef struct packed {
    logic               found;
    logic [MaxSelW-1:0] idx;
  } rr_grant_t;

  // First valid channel after last, wrapping modulo num_ch; last itself is scanned last.
  function automatic rr_grant_t next_rr(input logic [MaxSelW-1:0] last,
                                        input logic [MaxCh-1:0]   valid_vec,
                                        input int unsigned        num_ch);
    rr_grant_t          res;
    logic [MaxSelW-1:0] idx;
    int unsigned        sum;
    res = '0;
    for (int unsigned i = 1; i <= MaxCh; i++) begin
      if (i <= num_ch && !res.found) begin
        sum = 32'(last) + i;
        idx = MaxSelW'(sum % num_ch);
        if (valid_vec[idx]) begin
          res.found = 1'b1;
          res.idx   = idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the next valid channel after last_grant_i.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid_i,
  input  logic [SEL_W-1:0]  last_grant_i,
  output logic [SEL_W-1:0]  grant_idx_o,
  output logic              grant_found_o
);

  logic [MaxCh-1:0]   valid_pad;
  logic [MaxSelW-1:0] last_pad;
  rr_grant_t          res;
  logic               unused_idx;

  always_comb begin
    valid_pad               = '0;
    valid_pad[NUM_CH-1:0]   = valid_i;
    last_pad                = '0;
    last_pad[SEL_W-1:0]     = last_grant_i;
    res                     = next_rr(last_pad, valid_pad, NUM_CH);
    grant_idx_o             = res.idx[SEL_W-1:0];
    grant_found_o           = res.found;
  end

  assign unused_idx = ^res.idx;

endmodule

// File: rtl/mux_n1_rr_reset_ff.sv
// Registered N:1 mux with valid/ack handshakes, backpressure and explicit or round-robin select.
// Optional registered even parity output when MUX_PARITY_EN is defined.
module mux_n1_rr_reset_ff
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 2,
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        selector,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]       valid_in,
  output logic [NUM_CH-1:0]       ack_in,
  input  logic                    ready_out,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out,
  output logic [SEL_W-1:0]        ch_out
`ifdef MUX_PARITY_EN
  ,
  output logic                    parity_out
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             parity_q, parity_d;

  logic             load;
  logic             fire;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic [WIDTH-1:0] sel_word;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .valid_i       (valid_in),
    .last_grant_i  (last_q),
    .grant_idx_o   (rr_idx),
    .grant_found_o (rr_found)
  );

  always_comb begin
    load = ~valid_q | ready_out;
    if (mode == MODE_RR) begin
      grant_idx   = rr_idx;
      grant_found = rr_found;
    end else begin
      grant_idx   = selector;
      // Out-of-range selectors never grant when NUM_CH is not a power of two.
      grant_found = (32'(selector) < NUM_CH) && valid_in[selector];
    end
    fire     = reset_L & load & grant_found;
    sel_word = data_in[32'(grant_idx)*WIDTH +: WIDTH];

    ack_in = '0;
    if (fire) ack_in[grant_idx] = 1'b1;

    data_d   = data_q;
    valid_d  = valid_q;
    ch_d     = ch_q;
    last_d   = last_q;
    parity_d = parity_q;
    if (load) valid_d = fire;
    if (fire) begin
      data_d   = sel_word;
      ch_d     = grant_idx;
      parity_d = ^sel_word;
      if (mode == MODE_RR) last_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      ch_q     <= '0;
      last_q   <= SEL_W'(NUM_CH - 1);
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      parity_q <= parity_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign ch_out    = ch_q;

`ifdef MUX_PARITY_EN
  assign parity_out = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_n1_rr_reset_ff.sv
// Directed self-checking bench for mux_n1_rr_reset_ff (WIDTH=2, NUM_CH=4).
module tb_mux_n1_rr_reset_ff;

  logic       clk;
  logic       reset_L;
  logic       mode;
  logic [1:0] selector;
  logic [7:0] data_in;
  logic [3:0] valid_in;
  logic [3:0] ack_in;
  logic       ready_out;
  logic [1:0] data_out;
  logic       valid_out;
  logic [1:0] ch_out;
`ifdef MUX_PARITY_EN
  logic       parity_out;
`endif

  int total;
  int bad;

  mux_n1_rr_reset_ff #(
    .WIDTH  (2),
    .NUM_CH (4)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .mode      (mode),
    .selector  (selector),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ack_in    (ack_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ch_out    (ch_out)
`ifdef MUX_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L   = 1'b0;
    mode      = 1'b1;
    selector  = 2'd2;
    data_in   = 8'hFF;
    valid_in  = 4'b1111;
    ready_out = 1'b1;
    #1;
    total++;
    if (ack_in !== 4'b0000) begin
      bad++; $display("FAIL reset_ack got=%b want=0000", ack_in);
    end
    tick();
    tick();
    total++;
    if (data_out !== 2'b00) begin
      bad++; $display("FAIL reset_data got=%b want=00", data_out);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", valid_out);
    end
    total++;
    if (ch_out !== 2'd0) begin
      bad++; $display("FAIL reset_ch got=%0d want=0", ch_out);
    end
    total++;
    if (ack_in !== 4'b0000) begin
      bad++; $display("FAIL reset_ack_held got=%b want=0000", ack_in);
    end
  endtask

  task automatic test_explicit();
    reset_L   = 1'b1;
    mode      = 1'b0;
    selector  = 2'd2;
    valid_in  = 4'b0100;
    data_in   = 8'b00_11_00_00;
    ready_out = 1'b1;
    #1;
    total++;
    if (ack_in !== 4'b0100) begin
      bad++; $display("FAIL sel_ack got=%b want=0100", ack_in);
    end
    tick();
    total++;
    if (data_out !== 2'b11) begin
      bad++; $display("FAIL sel_data got=%b want=11", data_out);
    end
    total++;
    if (ch_out !== 2'd2) begin
      bad++; $display("FAIL sel_ch got=%0d want=2", ch_out);
    end
    total++;
    if (valid_out !== 1'b1) begin
      bad++; $display("FAIL sel_valid got=%b want=1", valid_out);
    end
  endtask

  // Channel k carries data 3-k so each source is distinguishable.
  task automatic test_round_robin();
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_ack;
    logic [1:0] exp_data;
    mode     = 1'b1;
    valid_in = 4'b1111;
    data_in  = {2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      exp_ack  = 4'b0001 << exp_ch[i];
      exp_data = 2'(3 - exp_ch[i]);
      #1;
      total++;
      if (ack_in !== exp_ack) begin
        bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", i, ack_in, exp_ack);
      end
      tick();
      total++;
      if (ch_out !== 2'(exp_ch[i]) || data_out !== exp_data || valid_out !== 1'b1) begin
        bad++;
        $display("FAIL rr_out[%0d] got ch=%0d data=%b v=%b want ch=%0d data=%b v=1",
                 i, ch_out, data_out, valid_out, exp_ch[i], exp_data);
      end
    end
  endtask

  task automatic test_backpressure();
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ack_in !== 4'b0000) begin
        bad++; $display("FAIL bp_ack[%0d] got=%b want=0000", i, ack_in);
      end
      tick();
      total++;
      if (ch_out !== 2'd0 || data_out !== 2'd3 || valid_out !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d] got ch=%0d data=%b v=%b want ch=0 data=11 v=1",
                 i, ch_out, data_out, valid_out);
      end
    end
    ready_out = 1'b1;
    #1;
    total++;
    if (ack_in !== 4'b0010) begin
      bad++; $display("FAIL bp_release_ack got=%b want=0010", ack_in);
    end
    tick();
    total++;
    if (ch_out !== 2'd1 || data_out !== 2'd2) begin
      bad++; $display("FAIL bp_release_out got ch=%0d data=%b want ch=1 data=10", ch_out, data_out);
    end
  endtask

  task automatic test_no_grant();
    mode     = 1'b0;
    selector = 2'd1;
    valid_in = 4'b0001;
    #1;
    total++;
    if (ack_in !== 4'b0000) begin
      bad++; $display("FAIL nogrant_ack got=%b want=0000", ack_in);
    end
    tick();
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL nogrant_valid got=%b want=0", valid_out);
    end
    total++;
    if (data_out !== 2'd2 || ch_out !== 2'd1) begin
      bad++; $display("FAIL nogrant_hold got data=%b ch=%0d want data=10 ch=1", data_out, ch_out);
    end
  endtask

  // Pointer sits at 1 after the backpressure release; only ch2 is valid.
  task automatic test_single_valid();
    mode     = 1'b1;
    valid_in = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (ack_in !== 4'b0100) begin
        bad++; $display("FAIL single_ack[%0d] got=%b want=0100", i, ack_in);
      end
      tick();
      total++;
      if (ch_out !== 2'd2 || data_out !== 2'd1) begin
        bad++; $display("FAIL single_out[%0d] got ch=%0d data=%b want ch=2 data=01",
                        i, ch_out, data_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_L = 1'b0;
    tick();
    reset_L  = 1'b1;
    mode     = 1'b1;
    valid_in = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (ch_out !== 2'(i)) begin
        bad++; $display("FAIL mid_pre_ch[%0d] got=%0d want=%0d", i, ch_out, i);
      end
    end
    reset_L = 1'b0;
    #1;
    total++;
    if (ack_in !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_ack got=%b want=0000", ack_in);
    end
    tick();
    total++;
    if (valid_out !== 1'b0 || data_out !== 2'd0 || ch_out !== 2'd0) begin
      bad++; $display("FAIL mid_reset_out got v=%b data=%b ch=%0d want v=0 data=00 ch=0",
                      valid_out, data_out, ch_out);
    end
    reset_L = 1'b1;
    #1;
    total++;
    if (ack_in !== 4'b0001) begin
      bad++; $display("FAIL mid_first_ack got=%b want=0001", ack_in);
    end
    tick();
    total++;
    if (ch_out !== 2'd0 || data_out !== 2'd3 || valid_out !== 1'b1) begin
      bad++; $display("FAIL mid_first_out got ch=%0d data=%b v=%b want ch=0 data=11 v=1",
                      ch_out, data_out, valid_out);
    end
  endtask

`ifdef MUX_PARITY_EN
  task automatic test_parity();
    mode     = 1'b0;
    selector = 2'd0;
    valid_in = 4'b0001;
    data_in  = 8'b00_00_00_01;
    tick();
    total++;
    if (parity_out !== 1'b1) begin
      bad++; $display("FAIL parity_01 got=%b want=1", parity_out);
    end
    data_in = 8'b00_00_00_11;
    tick();
    total++;
    if (parity_out !== 1'b0) begin
      bad++; $display("FAIL parity_11 got=%b want=0", parity_out);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_explicit();
    test_round_robin();
    test_backpressure();
    test_no_grant();
    test_single_valid();
    test_reset_mid();
`ifdef MUX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
